// File: rtl/pipe_stage_reg.sv
// Pipeline stage register carrying payload, destination tag and valid bit, with stall/flush
// control and hazard detection of the held tag against NSRC consumer read ports.
module pipe_stage_reg #(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned TNEW_W   = 2,
  parameter int unsigned TNEW_DEC = 1,
  parameter int unsigned NSRC     = 2,
  parameter int unsigned TUSE_W   = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     stall,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [4:0]               in_a3,
  input  logic                     in_rfwr,
  input  logic [TNEW_W-1:0]        in_tnew,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [4:0]               out_a3,
  output logic                     out_rfwr,
  output logic [TNEW_W-1:0]        out_tnew,
  input  logic [NSRC*5-1:0]        src_addr,
  input  logic [NSRC*TUSE_W-1:0]   src_tuse,
  output logic [NSRC-1:0]          hit,
  output logic [NSRC-1:0]          fwd_ready,
  output logic [NSRC-1:0]          stall_req,
  output logic [7:0]               stall_cnt
);

  localparam int unsigned CmpW = (TNEW_W > TUSE_W) ? TNEW_W : TUSE_W;

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [4:0]        a3_q, a3_d;
  logic              rfwr_q, rfwr_d;
  logic [TNEW_W-1:0] tnew_q, tnew_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [CmpW-1:0]   tnew_ext;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      a3_q    <= '0;
      rfwr_q  <= 1'b0;
      tnew_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      a3_q    <= a3_d;
      rfwr_q  <= rfwr_d;
      tnew_q  <= tnew_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    valid_d = 1'b0;
    data_d  = '0;
    a3_d    = '0;
    rfwr_d  = 1'b0;
    tnew_d  = '0;
    cnt_d   = '0;
    if (clr) begin
      // Bubble: the zero defaults above.
    end else if (stall) begin
      valid_d = valid_q;
      data_d  = data_q;
      a3_d    = a3_q;
      rfwr_d  = rfwr_q;
      tnew_d  = tnew_q;
      cnt_d   = (valid_q && cnt_q != 8'd255) ? cnt_q + 8'd1 : cnt_q;
    end else if (in_valid) begin
      valid_d = 1'b1;
      data_d  = in_data;
      a3_d    = in_a3;
      rfwr_d  = in_rfwr;
      // Saturating decrement: a zero Tnew never wraps to all-ones.
      if (TNEW_DEC != 0 && in_tnew != '0) begin
        tnew_d = in_tnew - 1'b1;
      end else begin
        tnew_d = in_tnew;
      end
    end
  end

  assign tnew_ext = CmpW'(tnew_q);

  always_comb begin
    hit       = '0;
    fwd_ready = '0;
    stall_req = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      hit[i]       = valid_q & rfwr_q & (a3_q != 5'd0) & (a3_q == src_addr[i*5 +: 5]);
      fwd_ready[i] = hit[i] & (tnew_q == '0);
      stall_req[i] = hit[i] & (tnew_ext > CmpW'(src_tuse[i*TUSE_W +: TUSE_W]));
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_a3    = a3_q;
  assign out_rfwr  = rfwr_q;
  assign out_tnew  = tnew_q;
  assign stall_cnt = cnt_q;

endmodule
